// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline register: state encoding
// (the state code doubles as the occupancy count) and bubble values.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic        BUBBLE_R          = 1'b0;
  localparam logic        BUBBLE_BIT        = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot {instr, p, r, e, valid}. Priority: reset > clear > load.
// Clear only invalidates; the data fields are left stale until the next load.
module pipe_slot #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32,
  parameter int EXC_W   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [DATA_W-1:0]  p_d,
  input  logic               r_d,
  input  logic [EXC_W-1:0]   e_d,
  output logic [INSTR_W-1:0] instr_q,
  output logic [DATA_W-1:0]  p_q,
  output logic               r_q,
  output logic [EXC_W-1:0]   e_q,
  output logic               vld_q
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      p_q     <= '0;
      r_q     <= 1'b0;
      e_q     <= '0;
    end else if (clear) begin
      vld_q <= 1'b0;
    end else if (load) begin
      vld_q   <= 1'b1;
      instr_q <= instr_d;
      p_q     <= p_d;
      r_q     <= r_d;
      e_q     <= e_d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register with ready/valid handshake, one-entry skid buffer,
// synchronous flush and occupancy reporting.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 EXC_W     = 3,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [DATA_W-1:0]  p_in,
  input  logic               r_in,
  input  logic [EXC_W-1:0]   e_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [DATA_W-1:0]  p_out,
  output logic               r_out,
  output logic [EXC_W-1:0]   e_out,
  output logic [1:0]         occupancy
);

  pipe_state_e state_q, state_d;

  logic               main_load, main_clear, skid_load, skid_clear, main_from_skid;
  logic               main_vld_p0, skid_vld_p0;
  logic [INSTR_W-1:0] main_instr_p0, skid_instr_p0, main_instr_d;
  logic [DATA_W-1:0]  main_p_p0, skid_p_p0, main_p_d;
  logic               main_r_p0, skid_r_p0, main_r_d;
  logic [EXC_W-1:0]   main_e_p0, skid_e_p0, main_e_d;
  logic               in_fire, out_fire;

  // in_ready comes straight from skid state, never from out_ready
  assign in_ready  = ~skid_vld_p0;
  assign out_valid = main_vld_p0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_q;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = FULL;
          main_load = 1'b1;
        end
      end
      FULL: begin
        if (out_fire && in_fire) begin
          main_load = 1'b1;
        end else if (out_fire) begin
          state_d    = EMPTY;
          main_clear = 1'b1;
        end else if (in_fire) begin
          state_d   = SKID;
          skid_load = 1'b1;
        end
      end
      SKID: begin
        if (out_fire) begin
          state_d        = FULL;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d    = EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  always_comb begin
    main_instr_d = main_from_skid ? skid_instr_p0 : instr_in;
    main_p_d     = main_from_skid ? skid_p_p0     : p_in;
    main_r_d     = main_from_skid ? skid_r_p0     : r_in;
    main_e_d     = main_from_skid ? skid_e_p0     : e_in;
  end

  // ---- slot register stage ----
  pipe_slot #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .EXC_W(EXC_W)) u_main (
    .clock   (clock),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .instr_d (main_instr_d),
    .p_d     (main_p_d),
    .r_d     (main_r_d),
    .e_d     (main_e_d),
    .instr_q (main_instr_p0),
    .p_q     (main_p_p0),
    .r_q     (main_r_p0),
    .e_q     (main_e_p0),
    .vld_q   (main_vld_p0)
  );

  pipe_slot #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .instr_d (instr_in),
    .p_d     (p_in),
    .r_d     (r_in),
    .e_d     (e_in),
    .instr_q (skid_instr_p0),
    .p_q     (skid_p_p0),
    .r_q     (skid_r_p0),
    .e_q     (skid_e_p0),
    .vld_q   (skid_vld_p0)
  );

  // ---- output bubble mux ----
  always_comb begin
    instr_out = main_vld_p0 ? main_instr_p0 : NOP_INSTR;
    p_out     = main_vld_p0 ? main_p_p0     : {DATA_W{BUBBLE_BIT}};
    r_out     = main_vld_p0 ? main_r_p0     : BUBBLE_R;
    e_out     = main_vld_p0 ? main_e_p0     : {EXC_W{BUBBLE_BIT}};
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, backpressure, flush,
// exception passthrough and mid-stream reset.
module tb_pipe_skid_reg;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, r_in, out_valid, out_ready, r_out;
  logic [31:0] instr_in, p_in, instr_out, p_out;
  logic [2:0]  e_in, e_out;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;

  pipe_skid_reg dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr_in  (instr_in),
    .p_in      (p_in),
    .r_in      (r_in),
    .e_in      (e_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_out (instr_out),
    .p_out     (p_out),
    .r_out     (r_out),
    .e_out     (e_out),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_instr"},     instr_out,      32'h0);
    chk({tag, "_p"},         p_out,          32'h0);
    chk({tag, "_r"},         32'(r_out),     32'd0);
    chk({tag, "_e"},         32'(e_out),     32'd0);
    chk({tag, "_occ"},       32'(occupancy), 32'd0);
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] p);
    in_valid = 1'b1;
    instr_in = ins;
    p_in     = p;
    r_in     = 1'b0;
    e_in     = 3'd0;
  endtask

  initial begin
    // reset with random inputs
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    instr_in  = $urandom;
    p_in      = $urandom;
    r_in      = 1'($urandom);
    e_in      = 3'($urandom);
    tick();
    tick();
    chk_bubble("reset");

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();

    // streaming
    push(32'h11, 32'd5);
    tick();
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_instr", instr_out, 32'h11);
    chk("s1_p", p_out, 32'd5);
    chk("s1_occ", 32'(occupancy), 32'd1);
    push(32'h22, 32'd6);
    tick();
    chk("s2_instr", instr_out, 32'h22);
    chk("s2_p", p_out, 32'd6);
    chk("s2_occ", 32'(occupancy), 32'd1);
    push(32'h33, 32'd7);
    tick();
    chk("s3_instr", instr_out, 32'h33);
    chk("s3_p", p_out, 32'd7);
    chk("s3_occ", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("s4_valid", 32'(out_valid), 32'd0);
    chk("s4_occ", 32'(occupancy), 32'd0);

    // backpressure
    out_ready = 1'b0;
    push(32'hA1, 32'd1);
    tick();
    chk("b1_instr", instr_out, 32'hA1);
    chk("b1_occ", 32'(occupancy), 32'd1);
    chk("b1_in_ready", 32'(in_ready), 32'd1);
    push(32'hA2, 32'd2);
    tick();
    chk("b2_occ", 32'(occupancy), 32'd2);
    chk("b2_in_ready", 32'(in_ready), 32'd0);
    chk("b2_instr", instr_out, 32'hA1);
    push(32'hA3, 32'd3);
    tick();
    chk("b3_occ", 32'(occupancy), 32'd2);
    chk("b3_instr", instr_out, 32'hA1);
    out_ready = 1'b1;
    tick();
    chk("b4_instr", instr_out, 32'hA2);
    chk("b4_occ", 32'(occupancy), 32'd1);
    chk("b4_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("b5_instr", instr_out, 32'hA3);
    chk("b5_p", p_out, 32'd3);
    chk("b5_occ", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("b6_valid", 32'(out_valid), 32'd0);
    chk("b6_occ", 32'(occupancy), 32'd0);

    // flush while two entries are held
    out_ready = 1'b0;
    push(32'hD1, 32'd8);
    tick();
    push(32'hD2, 32'd9);
    tick();
    chk("f0_occ", 32'(occupancy), 32'd2);
    flush = 1'b1;
    push(32'hB0, 32'd10);
    tick();
    chk_bubble("flush");
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("f2_valid", 32'(out_valid), 32'd0);
    chk("f2_instr", instr_out, 32'h0);
    chk("f2_occ", 32'(occupancy), 32'd0);

    // exception passthrough
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = 32'h44;
    p_in      = 32'hFFFF_FFFF;
    r_in      = 1'b1;
    e_in      = 3'b101;
    tick();
    chk("x1_e", 32'(e_out), 32'b101);
    chk("x1_r", 32'(r_out), 32'd1);
    chk("x1_p", p_out, 32'hFFFF_FFFF);
    chk("x1_instr", instr_out, 32'h44);
    in_valid  = 1'b0;
    r_in      = 1'b0;
    e_in      = 3'd0;
    out_ready = 1'b1;
    tick();
    chk_bubble("x2");

    // reset mid-operation
    out_ready = 1'b0;
    push(32'hE1, 32'd11);
    tick();
    push(32'hE2, 32'd12);
    tick();
    chk("m0_occ", 32'(occupancy), 32'd2);
    reset     = 1'b0;
    in_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    instr_in  = $urandom;
    p_in      = $urandom;
    r_in      = 1'($urandom);
    e_in      = 3'($urandom);
    tick();
    chk_bubble("mreset");
    reset     = 1'b1;
    out_ready = 1'b1;
    push(32'hC0, 32'h99);
    tick();
    chk("m2_valid", 32'(out_valid), 32'd1);
    chk("m2_instr", instr_out, 32'hC0);
    chk("m2_p", p_out, 32'h99);
    chk("m2_occ", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("m3_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
